pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard control for a single-issue pipeline. It detects EX->ID forwarding
//   opportunities and load-use hazards. It also sequences multi-cycle
//   load-use stalls and branch-flush windows.
//
// Parameters
//   LOAD_LAT   load-use stall length in cycles (1..7)
//   BR_PENALTY flush length in cycles after a taken branch/jump (1..7)
//   CNT_W      width of the stall/flush performance counter
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   id_aa, id_ba        ID-stage source register addresses (A, B)
//   id_ma, id_mb        ID operand muxes select PC / immediate (no reg read)
//   ex_da, ex_rw, ex_md EX destination, write enable, result source (01=load)
//   br_taken            EX branch/jump resolved taken
//   cnt_clr             synchronous clear of perf_cnt
//   ha, hb              forward EX result to BUS_A / BUS_B
//   stall, bubble       hold PC+IF/ID; inject NOP into ID/EX
//   flush               squash the IF/ID instruction
//   busy                controller is not in RUN
//   perf_cnt            saturating count of cycles with stall or flush
//
// Configuration
//   HAZ_PERF_CNT_EN     when defined, perf_cnt is a real counter; otherwise
//                       perf_cnt is tied to zero and cnt_clr is ignored.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_aa,
  input  logic [4:0]       id_ba,
  input  logic             id_ma,
  input  logic             id_mb,
  input  logic [4:0]       ex_da,
  input  logic             ex_rw,
  input  logic [1:0]       ex_md,
  input  logic             br_taken,
  input  logic             cnt_clr,
  output logic             ha,
  output logic             hb,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] perf_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    BFLUSH = 2'd2
  } state_t;

  // The detection cycle in RUN is already the first stall/flush cycle.
  // The FSM therefore covers only the remaining LAT-1 cycles. cyc holds the
  // cycles still to run after the current one, and a length of 1 never
  // leaves RUN.
  localparam bit       LD_MULTI  = (LOAD_LAT > 1);
  localparam bit       BR_MULTI  = (BR_PENALTY > 1);
  localparam logic [2:0] LD_RELOAD = LD_MULTI ? 3'(LOAD_LAT - 2)   : 3'd0;
  localparam logic [2:0] BR_RELOAD = BR_MULTI ? 3'(BR_PENALTY - 2) : 3'd0;

  state_t     state, state_nx;
  logic [2:0] cyc, cyc_nx;

  logic dst_ok, match_a, match_b, is_load, load_use;

  always_comb begin
    dst_ok   = ex_rw && (ex_da != '0);
    match_a  = (ex_da == id_aa) && !id_ma;
    match_b  = (ex_da == id_ba) && !id_mb;
    is_load  = (ex_md == 2'b01);
    load_use = dst_ok && is_load && (match_a || match_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cyc   <= '0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    ha       = 1'b0;
    hb       = 1'b0;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;

    case (state)
      RUN: begin
        ha     = dst_ok && !is_load && match_a;
        hb     = dst_ok && !is_load && match_b;
        flush  = br_taken;
        stall  = load_use && !br_taken;
        bubble = load_use && !br_taken;
        if (br_taken) begin
          if (BR_MULTI) begin
            state_nx = BFLUSH;
            cyc_nx   = BR_RELOAD;
          end
        end else if (load_use && LD_MULTI) begin
          state_nx = LSTALL;
          cyc_nx   = LD_RELOAD;
        end
      end
      LSTALL: begin
        stall  = 1'b1;
        bubble = 1'b1;
        flush  = br_taken;
        if (br_taken) begin
          state_nx = BR_MULTI ? BFLUSH : RUN;
          cyc_nx   = BR_RELOAD;
        end else if (cyc == '0) begin
          state_nx = RUN;
        end else begin
          cyc_nx = cyc - 3'd1;
        end
      end
      BFLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (cyc == '0) begin
          state_nx = RUN;
        end else begin
          cyc_nx = cyc - 3'd1;
        end
      end
      default: begin
        state_nx = RUN;
        cyc_nx   = '0;
      end
    endcase

    if (rst) begin
      ha     = 1'b0;
      hb     = 1'b0;
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
    end
  end

  assign busy = (state != RUN);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_q <= '0;
    end else if ((stall || flush) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign perf_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign perf_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_aa, id_ba, ex_da;
  logic       id_ma, id_mb, ex_rw, br_taken, cnt_clr;
  logic [1:0] ex_md;

  logic        a_ha, a_hb, a_stall, a_bubble, a_flush, a_busy;
  logic [3:0]  a_perf;
  logic        b_ha, b_hb, b_stall, b_bubble, b_flush, b_busy;
  logic [15:0] b_perf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(2), .BR_PENALTY(2), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .id_aa(id_aa), .id_ba(id_ba), .id_ma(id_ma),
    .id_mb(id_mb), .ex_da(ex_da), .ex_rw(ex_rw), .ex_md(ex_md),
    .br_taken(br_taken), .cnt_clr(cnt_clr), .ha(a_ha), .hb(a_hb),
    .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .busy(a_busy),
    .perf_cnt(a_perf)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .BR_PENALTY(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_aa(id_aa), .id_ba(id_ba), .id_ma(id_ma),
    .id_mb(id_mb), .ex_da(ex_da), .ex_rw(ex_rw), .ex_md(ex_md),
    .br_taken(br_taken), .cnt_clr(cnt_clr), .ha(b_ha), .hb(b_hb),
    .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .busy(b_busy),
    .perf_cnt(b_perf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_aa = '0; id_ba = '0; id_ma = 1'b0; id_mb = 1'b0;
    ex_da = '0; ex_rw = 1'b0; ex_md = 2'b00; br_taken = 1'b0;
  endtask

  // load on r7 feeding the B operand
  task automatic set_load_use();
    ex_rw = 1'b1; ex_md = 2'b01; ex_da = 5'd7; id_ba = 5'd7; id_mb = 1'b0;
  endtask

  function automatic logic [31:0] pexp(input int v);
    return PERF_ON ? 32'(v) : 32'd0;
  endfunction

  initial begin
    cnt_clr = 1'b0;
    clear_in();
    rst = 1'b1;
    // outputs forced low while reset even with hazards present
    set_load_use();
    br_taken = 1'b1;
    tick();
    #1;
    check("rst_stall",  32'(a_stall),  32'd0);
    check("rst_bubble", 32'(a_bubble), 32'd0);
    check("rst_flush",  32'(a_flush),  32'd0);
    check("rst_busy",   32'(a_busy),   32'd0);
    check("rst_perf",   32'(a_perf),   32'd0);
    tick();
    rst = 1'b0;
    clear_in();

    // forwarding, combinational
    ex_rw = 1'b1; ex_md = 2'b00; ex_da = 5'd5; id_aa = 5'd5; id_ba = 5'd3;
    #1;
    check("fwd_ha",    32'(a_ha),    32'd1);
    check("fwd_hb",    32'(a_hb),    32'd0);
    check("fwd_stall", 32'(a_stall), 32'd0);
    id_ma = 1'b1;
    #1;
    check("fwd_ha_muxpc", 32'(a_ha), 32'd0);
    id_ma = 1'b0; id_ba = 5'd5;
    #1;
    check("fwd_hb", 32'(a_hb), 32'd1);
    ex_rw = 1'b0;
    #1;
    check("fwd_ha_norw", 32'(a_ha), 32'd0);
    ex_rw = 1'b1; ex_da = 5'd0; id_aa = 5'd0; id_ba = 5'd0;
    #1;
    check("fwd_ha_r0", 32'(a_ha), 32'd0);
    check("fwd_hb_r0", 32'(a_hb), 32'd0);

    // load-use: u_a stalls 2 cycles, u_b 3 cycles
    tick();
    clear_in();
    set_load_use();
    #1;
    check("lu0_stall",  32'(a_stall),  32'd1);
    check("lu0_bubble", 32'(a_bubble), 32'd1);
    check("lu0_busy",   32'(a_busy),   32'd0);
    check("lu0_hb",     32'(a_hb),     32'd0);
    check("lu0_b_stall", 32'(b_stall), 32'd1);
    tick();
    clear_in();
    ex_rw = 1'b1; ex_md = 2'b00; ex_da = 5'd5; id_aa = 5'd5;
    #1;
    check("lu1_stall",  32'(a_stall),  32'd1);
    check("lu1_bubble", 32'(a_bubble), 32'd1);
    check("lu1_busy",   32'(a_busy),   32'd1);
    check("lu1_ha",     32'(a_ha),     32'd0);
    check("lu1_b_busy", 32'(b_busy),   32'd1);
    tick();
    clear_in();
    #1;
    check("lu2_stall",   32'(a_stall), 32'd0);
    check("lu2_busy",    32'(a_busy),  32'd0);
    check("lu2_b_stall", 32'(b_stall), 32'd1);
    check("lu2_perf",    32'(a_perf),  pexp(2));
    tick();
    #1;
    check("lu3_b_stall", 32'(b_stall), 32'd0);
    check("lu3_b_busy",  32'(b_busy),  32'd0);
    check("lu3_b_perf",  32'(b_perf),  pexp(3));

    // branch beats load-use; a second branch inside the flush is ignored
    set_load_use();
    br_taken = 1'b1;
    #1;
    check("br0_flush",  32'(a_flush),  32'd1);
    check("br0_stall",  32'(a_stall),  32'd0);
    check("br0_bubble", 32'(a_bubble), 32'd0);
    tick();
    clear_in();
    br_taken = 1'b1;
    #1;
    check("br1_flush",  32'(a_flush),  32'd1);
    check("br1_stall",  32'(a_stall),  32'd0);
    check("br1_bubble", 32'(a_bubble), 32'd1);
    check("br1_busy",   32'(a_busy),   32'd1);
    check("br1_b_busy", 32'(b_busy),   32'd0);
    tick();
    clear_in();
    #1;
    check("br2_flush", 32'(a_flush), 32'd0);
    check("br2_busy",  32'(a_busy),  32'd0);
    check("br2_perf",  32'(a_perf),  pexp(4));
    check("br2_b_perf", 32'(b_perf), pexp(5));

    // branch while stalled moves into the flush window
    set_load_use();
    tick();
    clear_in();
    br_taken = 1'b1;
    #1;
    check("lsbr1_stall", 32'(a_stall), 32'd1);
    tick();
    clear_in();
    #1;
    check("lsbr2_busy",   32'(a_busy),  32'd1);
    check("lsbr2_flush",  32'(a_flush), 32'd1);
    check("lsbr2_stall",  32'(a_stall), 32'd0);
    check("lsbr2_b_busy", 32'(b_busy),  32'd0);
    tick();
    #1;
    check("lsbr3_busy",   32'(a_busy),  32'd0);
    check("lsbr3_perf",   32'(a_perf),  pexp(7));
    check("lsbr3_b_perf", 32'(b_perf),  pexp(7));

    // reset during the first LSTALL cycle of u_b
    set_load_use();
    #1;
    check("rs0_b_stall", 32'(b_stall), 32'd1);
    tick();
    rst = 1'b1;
    set_load_use();
    #1;
    check("rs1_b_stall",  32'(b_stall),  32'd0);
    check("rs1_b_bubble", 32'(b_bubble), 32'd0);
    check("rs1_a_stall",  32'(a_stall),  32'd0);
    tick();
    rst = 1'b0;
    clear_in();
    #1;
    check("rs2_b_busy",  32'(b_busy),  32'd0);
    check("rs2_b_stall", 32'(b_stall), 32'd0);
    check("rs2_b_perf",  32'(b_perf),  32'd0);
    check("rs2_a_perf",  32'(a_perf),  32'd0);

    // 20 flush cycles: 4-bit counter saturates, 16-bit one does not
    br_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    br_taken = 1'b0;
    #1;
    check("sat_a_perf", 32'(a_perf), pexp(15));
    check("sat_b_perf", 32'(b_perf), pexp(20));
    tick();
    #1;
    check("sat_hold", 32'(a_perf), pexp(15));
    cnt_clr = 1'b1;
    br_taken = 1'b1;
    tick();
    cnt_clr = 1'b0;
    br_taken = 1'b0;
    #1;
    check("clr_a_perf", 32'(a_perf), 32'd0);
    check("clr_b_perf", 32'(b_perf), 32'd0);
    tick();
    #1;
    check("post_clr_a_perf", 32'(a_perf), pexp(1));
    check("post_clr_b_perf", 32'(b_perf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
